// File: rtl/deserialize_if.sv
// Stream-side bundle of the chain-tail deserializer: gated word stream in,
// reassembled parallel frame plus its strobe out.
interface deserialize_if #(
    parameter int dwi  = 28,
    parameter int n_ch = 4
);
    logic signed [dwi-1:0]      stream_in;
    logic                       gate_in;
    logic        [n_ch*dwi-1:0] data_out;
    logic                       strobe_out;

    // Upstream/observer side: drives the stream, watches the frame.
    modport master (
        output stream_in, gate_in,
        input  data_out, strobe_out
    );

    // Deserializer side.
    modport slave (
        input  stream_in, gate_in,
        output data_out, strobe_out
    );
endinterface

// File: rtl/deserialize.sv
// Reassembles one gated run of n_ch serial words into a parallel frame,
// flagging short and long runs with sticky error bits.
module deserialize #(
    parameter int dwi  = 28,
    parameter int n_ch = 4,
    parameter int cw   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    deserialize_if.slave      bus,
    input  logic              clr_err,
    output logic              short_err,
    output logic              long_err,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [cw-1:0]             cnt;
    // Only words 0..n_ch-2 are held; the last word goes straight to data_out.
    logic [(n_ch-1)*dwi-1:0]   frame_q;
    logic                      last_word;
    logic                      capture, deliver, short_evt, long_evt;

    assign last_word = (cnt == cw'(n_ch - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.gate_in) state_nxt = FILL;
            FILL:    if (!bus.gate_in)  state_nxt = IDLE;
                     else if (last_word) state_nxt = DRAIN;
            DRAIN:   if (!bus.gate_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture   = 1'b0;
        deliver   = 1'b0;
        short_evt = 1'b0;
        long_evt  = 1'b0;
        case (state)
            IDLE:  capture = bus.gate_in;
            FILL: begin
                capture   = bus.gate_in && !last_word;
                deliver   = bus.gate_in && last_word;
                short_evt = !bus.gate_in;
            end
            DRAIN: long_evt = bus.gate_in;
            default: ;
        endcase
    end

    // NOTE: the shift register is reset along with the control state so a
    // freshly reset block never exposes stale words; sequential state uses <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            frame_q        <= '0;
            bus.data_out   <= '0;
            bus.strobe_out <= 1'b0;
            frame_cnt      <= '0;
            short_err      <= 1'b0;
            long_err       <= 1'b0;
        end else begin
            bus.strobe_out <= deliver;
            if (capture) begin
                frame_q[int'(cnt)*dwi +: dwi] <= bus.stream_in;
                cnt <= cnt + 1'b1;
            end else if (deliver || short_evt) begin
                cnt <= '0;
            end
            if (deliver) begin
                bus.data_out <= {bus.stream_in, frame_q};
                frame_cnt    <= frame_cnt + 16'd1;
            end
            // A new error event on the same edge as clr_err wins.
            short_err <= short_evt | (short_err & ~clr_err);
            long_err  <= long_evt  | (long_err  & ~clr_err);
        end
    end

endmodule

// File: tb/tb_deserialize.sv
// Directed and randomized bench for deserialize, compared against a
// run-length reference model of the gated stream.
module tb_deserialize;
    localparam int dwi  = 28;
    localparam int n_ch = 4;
    localparam int cw   = 3;
    localparam int fw   = n_ch * dwi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_err = 1'b0;
    logic        short_err, long_err;
    logic [15:0] frame_cnt;

    deserialize_if #(.dwi(dwi), .n_ch(n_ch)) bus ();

    deserialize #(.dwi(dwi), .n_ch(n_ch), .cw(cw)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_err   (clr_err),
        .short_err (short_err),
        .long_err  (long_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: tracks the length of the current gated run.
    int              run_len = 0;
    logic [dwi-1:0]  run_words[$];
    logic [fw-1:0]   exp_data = '0;
    logic            exp_strobe = 1'b0;
    logic            exp_short = 1'b0;
    logic            exp_long = 1'b0;
    logic [15:0]     exp_cnt = '0;

    task automatic model_reset();
        run_len = 0;
        run_words.delete();
        exp_data = '0;
        exp_strobe = 1'b0;
        exp_short = 1'b0;
        exp_long = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic model_edge(input logic g, input logic [dwi-1:0] w, input logic c);
        logic s_ev, l_ev;
        s_ev = 1'b0;
        l_ev = 1'b0;
        exp_strobe = 1'b0;
        if (g) begin
            run_len++;
            if (run_len <= n_ch) run_words.push_back(w);
            if (run_len == n_ch) begin
                for (int k = 0; k < n_ch; k++) exp_data[k*dwi +: dwi] = run_words[k];
                exp_strobe = 1'b1;
                exp_cnt++;
            end
            if (run_len > n_ch) l_ev = 1'b1;
        end else begin
            if (run_len > 0 && run_len < n_ch) s_ev = 1'b1;
            run_len = 0;
            run_words.delete();
        end
        exp_short = s_ev | (exp_short & ~c);
        exp_long  = l_ev | (exp_long & ~c);
    endtask

    task automatic check(input string tag, input logic [fw-1:0] obs, input logic [fw-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".strobe"},    fw'(bus.strobe_out), fw'(exp_strobe));
        check({tag, ".data"},      bus.data_out,         exp_data);
        check({tag, ".short_err"}, fw'(short_err),       fw'(exp_short));
        check({tag, ".long_err"},  fw'(long_err),        fw'(exp_long));
        check({tag, ".frame_cnt"}, fw'(frame_cnt),       fw'(exp_cnt));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare #1 later.
    task automatic step(input string tag, input logic g, input logic [dwi-1:0] w, input logic c);
        bus.gate_in   = g;
        bus.stream_in = w;
        clr_err       = c;
        @(posedge clk);
        model_edge(g, w, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [fw-1:0] lit;
        bus.gate_in   = 1'b0;
        bus.stream_in = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Good frame: 1,2,3,-4
        step("good0", 1'b1, dwi'(1), 1'b0);
        step("good1", 1'b1, dwi'(2), 1'b0);
        step("good2", 1'b1, dwi'(3), 1'b0);
        step("good3", 1'b1, dwi'(-4), 1'b0);
        lit = {dwi'(-4), dwi'(3), dwi'(2), dwi'(1)};
        check("good_literal", bus.data_out, lit);
        step("good_end", 1'b0, '0, 1'b0);

        // Short run: 5,6
        step("short0", 1'b1, dwi'(5), 1'b0);
        step("short1", 1'b1, dwi'(6), 1'b0);
        step("short_end", 1'b0, '0, 1'b0);
        check("short_keeps_data", bus.data_out, lit);

        // Long run: 10..15
        for (int i = 0; i < 6; i++) step("long", 1'b1, dwi'(10 + i), 1'b0);
        lit = {dwi'(13), dwi'(12), dwi'(11), dwi'(10)};
        check("long_literal", bus.data_out, lit);
        step("long_end", 1'b0, '0, 1'b0);

        // Error clear race: short-run end together with clr_err
        step("race0", 1'b1, dwi'(7), 1'b0);
        step("race_end", 1'b0, '0, 1'b1);
        check("race_short", fw'(short_err), fw'(1'b1));
        check("race_long",  fw'(long_err),  fw'(1'b0));
        step("clr_only", 1'b0, '0, 1'b1);

        // Back-to-back runs with one idle cycle, then with zero gap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < n_ch; i++) step("b2b_gap", 1'b1, dwi'($urandom), 1'b0);
            step("b2b_gap_idle", 1'b0, '0, 1'b0);
        end
        for (int i = 0; i < 2 * n_ch; i++) step("b2b_nogap", 1'b1, dwi'($urandom), 1'b0);
        step("b2b_nogap_end", 1'b0, '0, 1'b1);

        // Reset mid-frame
        step("rst_mid0", 1'b1, dwi'(21), 1'b0);
        step("rst_mid1", 1'b1, dwi'(22), 1'b0);
        rst_n = 1'b0;
        bus.gate_in = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < n_ch; i++) step("post_rst", 1'b1, dwi'(30 + i), 1'b0);
        check("post_rst_cnt", fw'(frame_cnt), fw'(16'd1));
        step("post_rst_end", 1'b0, '0, 1'b0);

        // Randomized gated stream
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), dwi'($urandom),
                 ($urandom_range(0, 15) == 0));
        end
        step("final", 1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deserialize.md
Name: deserialize

Overview:
- Receive end of the gated sample-stream chain: accepts the word-serial stream (stream_in plus gate_in) that a chain of serializer stages shifts out after each sample strobe.
- Reassembles one gated run of n_ch words into a parallel frame and presents it on data_out with a one-cycle strobe_out.
- Sits at the chain tail, ahead of per-channel processing or register readout.
- Detects short and long runs and flags them with sticky error bits.

Parameters:
- dwi, 28, word width of each stream word.
- n_ch, 4, words per frame (chain length); n_ch >= 2.
- cw, 3, word-counter width; 2**cw > n_ch is required.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- stream_in  input  dwi (signed)  serial data word, valid when gate_in=1.
- gate_in  input  1  word-valid; a frame is one contiguous run of gate_in=1 cycles.
- clr_err  input  1  synchronous clear of the sticky error flags.
- data_out  output  n_ch*dwi  last complete frame; word k (k-th gated word of the run, k=0 first) at bits [(k+1)*dwi-1 : k*dwi].
- strobe_out  output  1  one-cycle pulse: data_out just updated.
- short_err  output  1  sticky: a run ended with fewer than n_ch words.
- long_err  output  1  sticky: a run exceeded n_ch words.
- frame_cnt  output  16  count of good frames delivered, wraps 0xFFFF->0.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following go to 0: data_out, strobe_out, short_err, long_err, frame_cnt, word counter, internal shift register; state goes to IDLE. Release is synchronous to clk.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - gate_in=1 → capture word 0, cnt<=1, go to FILL.
  - gate_in=0 → stay.
- FILL, gate_in=1 and cnt<n_ch-1: capture word cnt, cnt<=cnt+1.
- FILL, gate_in=1 and cnt==n_ch-1:
  - On the same edge: data_out <= assembled frame including current stream_in, strobe_out<=1, frame_cnt+=1.
  - Go to DRAIN.
- FILL, gate_in=0: run too short.
  - Discard partial frame; data_out unchanged, no strobe.
  - short_err<=1, cnt<=0, go to IDLE.
- DRAIN:
  - gate_in=0 → IDLE.
  - gate_in=1 → extra word ignored, long_err<=1, stay in DRAIN.
  - A delivered frame is never revoked by a later overrun.
- Latency: strobe_out is high in the cycle after the edge that samples the n_ch-th word; data_out is stable from that cycle until the next strobe.
- strobe_out is high for exactly one cycle per good frame.
- Back-to-back frames need at least one gate_in=0 cycle between runs. Without it, the two runs merge into one run, which is treated as a long run.
- Words presented with gate_in=0 are never captured; stream_in is don't-care then.
- clr_err=1 clears both sticky flags next edge. If an error event occurs on the same edge, the set wins.
- frame_cnt increments on the same edge that raises strobe_out.
- No arithmetic on data; words are passed bit-exact, sign preserved.

Test Plan:
- Good frame: n_ch=4, gate_in=1 for 4 cycles with words 1,2,3,-4 → one strobe_out the cycle after word -4; data_out = {-4,3,2,1} (word0=1 in LSB slice); frame_cnt=1; no errors.
- Short run: gate_in=1 for 2 cycles (words 5,6), then low → no strobe; data_out keeps its previous frame; short_err=1 from the next edge.
- Long run: gate_in=1 for 6 cycles (words 10..15) → strobe after word 13; data_out={13,12,11,10}; long_err=1; returns to IDLE when gate drops.
- Back-to-back runs: two 4-word runs separated by one idle cycle → two strobes 5 cycles apart; frame_cnt=2. The same runs with zero-gap separation → one strobe and long_err=1.
- Error clear race: long_err=1; assert clr_err on the same edge as a new short-run end → short_err=1, long_err=0. clr_err alone → both 0.
- Reset mid-frame: pull rst_n low after 2 gated words → all outputs 0 immediately (asynchronous). After release, a full 4-word run produces a correct frame with frame_cnt=1.
